// File: rtl/sdrd_deserializer_pkg.sv
// Shared types and constants for the SDRD serial-to-parallel deserializer.
// The optional odd-parity frame is enabled with the SDRD_PARITY_EN macro.
package sdrd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FULL  = 2'd2
    } sdrd_state_e;

    // Address bits that select the 0x1xxx serial window.
    localparam logic BA13_SEL = 1'b0;
    localparam logic BA12_SEL = 1'b1;

    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/sdrd_deserializer_if.sv
// Bus-side and host-side signal bundle of the SDRD deserializer.
// Carries parity_err only when SDRD_PARITY_EN is defined.
interface sdrd_deserializer_if #(
    parameter int WIDTH = 8
);
    import sdrd_pkg::*;

    localparam int CW = cnt_w(WIDTH);

    logic             sser_n;
    logic             ba13;
    logic             ba12;
    logic             br_w;
    logic             sdrd;
    logic             word_ack;
    logic [WIDTH-1:0] word_out;
    logic             word_valid;
    logic [CW-1:0]    bit_cnt;
    logic             overrun;
`ifdef SDRD_PARITY_EN
    logic             parity_err;
`endif
    sdrd_state_e      state;

    // Handshake: word_valid holds word_out until a cycle with word_ack=1;
    // the word retires on that edge. word_ack with word_valid=0 is ignored.
    modport master (
        output sser_n, ba13, ba12, br_w, sdrd, word_ack,
        input  word_out, word_valid, bit_cnt, overrun, state
`ifdef SDRD_PARITY_EN
        , parity_err
`endif
    );

    modport slave (
        input  sser_n, ba13, ba12, br_w, sdrd, word_ack,
        output word_out, word_valid, bit_cnt, overrun, state
`ifdef SDRD_PARITY_EN
        , parity_err
`endif
    );

endinterface

// File: rtl/sdrd_deserializer_acc_edge.sv
// Decodes serial-window reads/writes and emits a one-clock strobe
// on the first cycle of each access.
module sdrd_acc_edge
    import sdrd_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic sser_n_i,
    input  logic ba13_i,
    input  logic ba12_i,
    input  logic br_w_i,
    output logic rd_strobe_o,
    output logic wr_strobe_o
);

    logic sel;
    logic rd_acc;
    logic wr_acc;
    logic rd_acc_q;
    logic wr_acc_q;

    assign sel    = ~sser_n_i & (ba13_i == BA13_SEL) & (ba12_i == BA12_SEL);
    assign rd_acc = sel & br_w_i;
    assign wr_acc = sel & ~br_w_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_acc_q <= 1'b0;
            wr_acc_q <= 1'b0;
        end else begin
            rd_acc_q <= rd_acc;
            wr_acc_q <= wr_acc;
        end
    end

    assign rd_strobe_o = rd_acc & ~rd_acc_q;
    assign wr_strobe_o = wr_acc & ~wr_acc_q;

endmodule

// File: rtl/sdrd_deserializer.sv
// Assembles one SDRD bit per serial-window read into WIDTH-bit words and
// hands them to the host with valid/ack. SDRD_PARITY_EN adds an odd-parity bit.
module sdrd_deserializer
    import sdrd_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    sdrd_deserializer_if.slave bus
);

`ifdef SDRD_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    localparam int            CW   = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(FRAME - 1);

    logic rd_strobe;
    logic wr_strobe;

    sdrd_state_e      state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [FRAME-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             ovr_q, ovr_d;
    logic [FRAME-1:0] frame_in;
    logic [WIDTH-1:0] data_in;
    logic             ack_hit;
    logic             complete;
`ifdef SDRD_PARITY_EN
    logic             par_in;
    logic             perr_q, perr_d;
`endif

    sdrd_acc_edge u_acc_edge (
        .clk         (clk),
        .rst_n       (rst_n),
        .sser_n_i    (bus.sser_n),
        .ba13_i      (bus.ba13),
        .ba12_i      (bus.ba12),
        .br_w_i      (bus.br_w),
        .rd_strobe_o (rd_strobe),
        .wr_strobe_o (wr_strobe)
    );

    // Frame as it would look with the current sdrd bit shifted in.
    always_comb begin
        frame_in = '0;
        if (MSB_FIRST) frame_in = {sh_q[FRAME-2:0], bus.sdrd};
        else           frame_in = {bus.sdrd, sh_q[FRAME-1:1]};
    end

`ifdef SDRD_PARITY_EN
    always_comb begin
        data_in = '0;
        par_in  = 1'b0;
        if (MSB_FIRST) begin
            data_in = frame_in[FRAME-1:1];
            par_in  = frame_in[0];
        end else begin
            data_in = frame_in[WIDTH-1:0];
            par_in  = frame_in[FRAME-1];
        end
    end
`else
    assign data_in = frame_in;
`endif

    assign ack_hit  = bus.word_ack && (state_q == FULL);
    assign complete = rd_strobe && (cnt_q == LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        word_d  = word_q;
        ovr_d   = ovr_q;
`ifdef SDRD_PARITY_EN
        perr_d  = perr_q;
`endif
        if (wr_strobe) begin
            cnt_d   = '0;
            sh_d    = '0;
            state_d = (state_q == FULL && !ack_hit) ? FULL : IDLE;
        end else if (complete) begin
            cnt_d   = '0;
            sh_d    = '0;
            state_d = FULL;
`ifdef SDRD_PARITY_EN
            perr_d  = ~(^data_in ^ par_in);
`endif
            // An ack in the completing cycle frees the slot for the new word.
            if (state_q != FULL || ack_hit) word_d = data_in;
            else                            ovr_d  = 1'b1;
        end else if (rd_strobe) begin
            cnt_d   = cnt_q + CW'(1);
            sh_d    = frame_in;
            state_d = (state_q == FULL && !ack_hit) ? FULL : SHIFT;
        end else if (ack_hit) begin
            state_d = (cnt_q == '0) ? IDLE : SHIFT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            word_q  <= '0;
            ovr_q   <= 1'b0;
`ifdef SDRD_PARITY_EN
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            word_q  <= word_d;
            ovr_q   <= ovr_d;
`ifdef SDRD_PARITY_EN
            perr_q  <= perr_d;
`endif
        end
    end

    assign bus.word_out   = word_q;
    assign bus.word_valid = (state_q == FULL);
    assign bus.bit_cnt    = cnt_q;
    assign bus.overrun    = ovr_q;
    assign bus.state      = state_q;
`ifdef SDRD_PARITY_EN
    assign bus.parity_err = perr_q;
`endif

endmodule

// File: tb/tb_sdrd_deserializer.sv
// Directed self-checking bench for sdrd_deserializer (WIDTH=8, MSB_FIRST=1).
// Parity cases run only when SDRD_PARITY_EN is defined.
module tb_sdrd_deserializer;
    import sdrd_pkg::*;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    logic [7:0] exp_q[$];
    logic [7:0] exp_w;

    sdrd_deserializer_if #(.WIDTH(8)) bus ();

    sdrd_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic bus_idle();
        bus.sser_n   = 1'b1;
        bus.ba13     = 1'b0;
        bus.ba12     = 1'b0;
        bus.br_w     = 1'b1;
        bus.sdrd     = 1'b0;
        bus.word_ack = 1'b0;
    endtask

    // One single-cycle access in the 0x1xxx window.
    task automatic access(input logic rd, input logic b, input logic ack);
        @(negedge clk);
        bus.sser_n   = 1'b0;
        bus.ba13     = 1'b0;
        bus.ba12     = 1'b1;
        bus.br_w     = rd;
        bus.sdrd     = b;
        bus.word_ack = ack;
        @(negedge clk);
        bus_idle();
    endtask

    task automatic send_word(input logic [7:0] w, input logic ack_last);
`ifdef SDRD_PARITY_EN
        for (int i = 7; i >= 0; i--) access(1'b1, w[i], 1'b0);
        access(1'b1, ~^w, ack_last);
`else
        for (int i = 7; i >= 0; i--) access(1'b1, w[i], (i == 0) ? ack_last : 1'b0);
`endif
    endtask

    task automatic ack_pulse();
        @(negedge clk);
        bus.word_ack = 1'b1;
        @(negedge clk);
        bus.word_ack = 1'b0;
    endtask

    task automatic pop_chk(input string tag);
        exp_w = exp_q.pop_front();
        chk(tag, 16'(bus.word_out), 16'(exp_w));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        bus_idle();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_word", 16'(bus.word_out), 16'h0);
        chk("rst_valid", 16'(bus.word_valid), 16'h0);
        chk("rst_cnt", 16'(bus.bit_cnt), 16'h0);
        chk("rst_ovr", 16'(bus.overrun), 16'h0);
        rst_n = 1'b1;

        // Basic MSB-first word 1,0,1,1,0,0,1,0 = 0xB2.
        exp_w = 8'hB2;
        for (int i = 7; i >= 1; i--) access(1'b1, exp_w[i], 1'b0);
`ifndef SDRD_PARITY_EN
        chk("cnt_7", 16'(bus.bit_cnt), 16'd7);
        chk("shift_st", 16'(bus.state), 16'(SHIFT));
`endif
        access(1'b1, exp_w[0], 1'b0);
`ifdef SDRD_PARITY_EN
        access(1'b1, ~^exp_w, 1'b0);
`endif
        exp_q.push_back(8'hB2);
        chk("basic_valid", 16'(bus.word_valid), 16'h1);
        pop_chk("basic_word");
        chk("basic_cnt", 16'(bus.bit_cnt), 16'h0);
        chk("full_st", 16'(bus.state), 16'(FULL));
        ack_pulse();
        chk("ack_valid", 16'(bus.word_valid), 16'h0);
        chk("idle_st", 16'(bus.state), 16'(IDLE));
        ack_pulse();
        chk("stray_ack", 16'(bus.state), 16'(IDLE));

        // Long read: held 5 clocks, only the first cycle samples.
        @(negedge clk);
        bus.sser_n = 1'b0;
        bus.ba13   = 1'b0;
        bus.ba12   = 1'b1;
        bus.br_w   = 1'b1;
        bus.sdrd   = 1'b1;
        repeat (4) begin
            @(negedge clk);
            bus.sdrd = ~bus.sdrd;
        end
        @(negedge clk);
        bus_idle();
        chk("long_cnt", 16'(bus.bit_cnt), 16'd1);
        chk("long_st", 16'(bus.state), 16'(SHIFT));

        // Resync: two more bits, a write, then a clean 0x5A.
        access(1'b1, 1'b0, 1'b0);
        access(1'b1, 1'b1, 1'b0);
        chk("pre_sync_cnt", 16'(bus.bit_cnt), 16'd3);
        access(1'b0, 1'b0, 1'b0);
        chk("sync_cnt", 16'(bus.bit_cnt), 16'd0);
        chk("sync_st", 16'(bus.state), 16'(IDLE));
        send_word(8'h5A, 1'b0);
        exp_q.push_back(8'h5A);
        pop_chk("sync_word");
        ack_pulse();

        // Overrun: second word completes while the first is unacknowledged.
        send_word(8'h11, 1'b0);
        exp_q.push_back(8'h11);
        send_word(8'h22, 1'b0);
        pop_chk("ovr_word");
        chk("ovr_flag", 16'(bus.overrun), 16'h1);
        chk("ovr_valid", 16'(bus.word_valid), 16'h1);

        // Asynchronous reset mid-word, checked before any clock edge.
        access(1'b1, 1'b1, 1'b0);
        access(1'b1, 1'b0, 1'b0);
        access(1'b1, 1'b1, 1'b0);
        chk("mid_cnt", 16'(bus.bit_cnt), 16'd3);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_word", 16'(bus.word_out), 16'h0);
        chk("arst_valid", 16'(bus.word_valid), 16'h0);
        chk("arst_cnt", 16'(bus.bit_cnt), 16'h0);
        chk("arst_ovr", 16'(bus.overrun), 16'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Ack in the completing cycle swaps words without overrun.
        send_word(8'h11, 1'b0);
        send_word(8'h22, 1'b1);
        exp_q.push_back(8'h22);
        pop_chk("swap_word");
        chk("swap_ovr", 16'(bus.overrun), 16'h0);
        chk("swap_valid", 16'(bus.word_valid), 16'h1);
        ack_pulse();
        chk("swap_ack", 16'(bus.word_valid), 16'h0);

`ifdef SDRD_PARITY_EN
        for (int i = 7; i >= 0; i--) access(1'b1, 1'((8'h03 >> i) & 8'h01), 1'b0);
        access(1'b1, 1'b1, 1'b0);
        chk("par_ok", 16'(bus.parity_err), 16'h0);
        ack_pulse();
        for (int i = 7; i >= 0; i--) access(1'b1, 1'((8'h03 >> i) & 8'h01), 1'b0);
        access(1'b1, 1'b0, 1'b0);
        chk("par_err", 16'(bus.parity_err), 16'h1);
        exp_q.push_back(8'h03);
        pop_chk("par_word");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sdrd_deserializer.md
Name: sdrd_deserializer

Overview:
- Downstream consumer of the CLE04a SDRD serial read-data line. It samples one SDRD bit per qualifying bus read in the 0x1xxx window (SSER low, BA13 low, BA12 high, BR_W high) and assembles WIDTH bits into a parallel word.
- It presents each completed word to the host logic with a valid/ack handshake.
- It sits between the GAL's SDRD pin and the board's parallel data-latch / CPU read path.

Parameters:
- WIDTH, 8: bits per assembled word (legal range 2..16).
- MSB_FIRST, 1: 1 = first sampled bit lands in word[WIDTH-1]; 0 = first sampled bit lands in word[0].

Ports:
- clk, input, 1: system clock; all state changes on its rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- sser_n, input, 1: serial-select strobe, active low.
- ba13, input, 1: bus address bit 13.
- ba12, input, 1: bus address bit 12.
- br_w, input, 1: bus read/write; 1 = read.
- sdrd, input, 1: serial data bit from the GAL; valid only during qualifying reads.
- word_ack, input, 1: consumer acknowledges word_out.
- word_out, output, WIDTH: last completed word.
- word_valid, output, 1: word_out holds an unacknowledged word.
- bit_cnt, output, clog2(WIDTH+1): bits currently held in the shift register.
- overrun, output, 1: sticky; set when a word completes while word_valid is still high.

Behaviour:
- Reset values (rst_n low): word_out=0, word_valid=0, bit_cnt=0, overrun=0, shift register=0, FSM=IDLE, acc_q=0. Reset is asynchronous and may assert mid-word; the partial word is discarded.
- Access decode:
  - rd_acc = ~sser_n & ~ba13 & ba12 & br_w.
  - wr_acc is the same decode with br_w=0.
  - acc_q is the registered copy of rd_acc.
  - Sample strobe = rd_acc & ~acc_q, i.e. the first clk of each read access. One bit is taken per access regardless of access length.
- Shift:
  - On a strobe, sdrd is shifted in (direction set by MSB_FIRST) and bit_cnt increments.
  - On the strobe that brings bit_cnt to WIDTH, the completed word is transferred and bit_cnt returns to 0 in that same cycle.
- Resync: wr_acc at a rising edge (same edge detect applied to wr_acc) clears bit_cnt and the shift register; the FSM returns to IDLE or stays in FULL. A write takes priority over a simultaneous read strobe, which is impossible by decode anyway.
- FSM states:
  - IDLE: bit_cnt==0, word_valid==0.
  - SHIFT: 0<bit_cnt<WIDTH.
  - FULL: word_valid==1.
  - Shifting continues in FULL; a completion while in FULL is handled by the overrun rule below.
- Transitions:
  - IDLE→SHIFT on a strobe.
  - SHIFT→FULL on the completing strobe.
  - FULL→IDLE on word_ack when bit_cnt==0; FULL→SHIFT on word_ack when bit_cnt>0.
- Latency: word_valid rises the clk after the completing strobe edge; word_out is stable from that cycle.
- Handshake:
  - word_valid stays high until a cycle with word_ack=1; it clears on the next edge.
  - word_ack while word_valid=0 is ignored.
- Simultaneous completion and ack: the ack retires the old word and the new word loads. word_valid stays 1, overrun does not set.
- Overrun: completion while word_valid=1 and word_ack=0:
  - the new word is dropped;
  - word_out keeps the old word;
  - overrun is set to 1 and cleared only by rst_n.

Optional Feature:
- Macro: SDRD_PARITY_EN.
- Defined:
  - Each frame is WIDTH+1 bits; the last bit is odd parity over the data.
  - Adds output parity_err, 1 bit, reset 0, updated at every completion: 1 if the parity bit mismatches.
  - The word is still delivered when parity_err=1.
- Undefined: frames are WIDTH bits and the parity_err port does not exist.

Decomposition:
- Package sdrd_pkg holds:
  - the FSM state enum (IDLE, SHIFT, FULL);
  - the decode constants (BA13_SEL=0, BA12_SEL=1);
  - a function cnt_w(width) returning clog2(width+1).
- One sub-module, sdrd_acc_edge: access decode plus rising-edge detect; outputs rd_strobe and wr_strobe. The top holds the shift register, counter, FSM and handshake.

Test Plan:
- Reset value check: assert rst_n low mid-frame after 3 strobes → all outputs 0 immediately, before any clk edge.
- Basic word, WIDTH=8, MSB_FIRST=1: 8 single-cycle read accesses with sdrd=1,0,1,1,0,0,1,0 → word_out=8'hB2, word_valid=1 one clk after the 8th strobe, bit_cnt=0.
- Long access: one read held 5 clks with sdrd toggling → exactly one bit sampled, bit_cnt=1.
- Resync: 3 strobes, then one write access, then 8 strobes with sdrd=8'h5A bits → word_out=8'h5A.
- Handshake and overrun:
  - Complete word 8'h11 and hold word_ack=0, then complete word 8'h22 → word_out=8'h11, overrun=1.
  - Repeat with word_ack=1 on the completing cycle → word_out=8'h22, overrun=0.
- With SDRD_PARITY_EN: frame 8'h03 with parity bit 1 → parity_err=0; frame 8'h03 with parity bit 0 → parity_err=1 and word_out=8'h03.
